// File: rtl/vco_adc_pkg.sv
// rtl/vco_adc_pkg.sv - shared types, defaults and helpers for the VCO ADC edge decoder
package vco_adc_pkg;

    // Decoder control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } vco_state_e;

    localparam int CW_DEFAULT    = 8;
    localparam int WIN_W_DEFAULT = 8;

    // Largest code representable in cw bits; the edge counter sticks here
    function automatic logic [31:0] code_max(input int cw);
        code_max = (32'd1 << cw) - 32'd1;
    endfunction

endpackage

// File: rtl/vco_edge_sync.sv
// rtl/vco_edge_sync.sv - optional q_in synchronizer (VCO_EDGE_DECODER_SYNC_EN) plus rising-edge detector
module vco_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic q_in,
    output logic rise
);

    logic q_s;
    logic q_d;  // previous sample of the (optionally synchronized) VCO bit

`ifdef VCO_EDGE_DECODER_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for a q_in that is not already flopped in clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], q_in};
        end
    end

    assign q_s = sync_q[1];
`else
    assign q_s = q_in;
`endif

    // Previous-sample register; it tracks every cycle so the PRIME cycle
    // loads it with the live value and the first RUN cycle sees no false edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_d <= 1'b0;
        end else begin
            q_d <= q_s;
        end
    end

    assign rise = q_s & ~q_d;

endmodule

// File: rtl/vco_edge_decoder.sv
// rtl/vco_edge_decoder.sv - counts VCO rising edges per programmable window; optional input sync via VCO_EDGE_DECODER_SYNC_EN
module vco_edge_decoder
    import vco_adc_pkg::*;
#(
    parameter int CW    = CW_DEFAULT,
    parameter int WIN_W = WIN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             q_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CW-1:0]    code,
    output logic             code_valid,
    input  logic             code_ready,
    output logic             sat,
    output logic             overrun,
    output logic             busy
);

    localparam logic [CW-1:0] CODE_MAX = CW'(code_max(CW));

    vco_state_e       state_q, state_d;
    logic [CW-1:0]    edge_cnt_q, edge_cnt_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             flag_q, flag_d;
    logic [CW-1:0]    code_q, code_d;
    logic             code_valid_q, code_valid_d;
    logic             sat_q, sat_d;
    logic             overrun_q, overrun_d;

    logic             rise;
    logic             at_max;
    logic [CW-1:0]    cnt_next;
    logic             flag_next;
    logic [WIN_W-1:0] win_start;
    logic             close;
    logic [CW-1:0]    close_cnt;
    logic             close_sat;

    vco_edge_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .q_in  (q_in),
        .rise  (rise)
    );

    // A zero window length behaves as a one-cycle window
    assign win_start = (win_len == '0) ? '0 : win_len - 1'b1;
    assign at_max    = (edge_cnt_q == CODE_MAX);
    assign cnt_next  = (rise && !at_max) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    assign flag_next = flag_q | (rise & at_max);

    // Window sequencing: prime, count edges, close and restart back to back
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        win_cnt_d  = win_cnt_q;
        flag_d     = flag_q;
        close      = 1'b0;
        close_cnt  = edge_cnt_q;
        close_sat  = flag_q;
        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                win_cnt_d  = '0;
                flag_d     = 1'b0;
                if (en) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                edge_cnt_d = '0;
                flag_d     = 1'b0;
                if (!en) begin
                    state_d   = IDLE;
                    win_cnt_d = '0;
                end else begin
                    state_d   = RUN;
                    win_cnt_d = win_start;
                end
            end
            RUN: begin
                if (!en) begin
                    // Partial window is thrown away
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    win_cnt_d  = '0;
                    flag_d     = 1'b0;
                end else if (win_cnt_q == '0) begin
                    // Last window cycle: a rise here still counts
                    close      = 1'b1;
                    close_cnt  = cnt_next;
                    close_sat  = flag_next;
                    edge_cnt_d = '0;
                    flag_d     = 1'b0;
                    win_cnt_d  = win_start;
                end else begin
                    edge_cnt_d = cnt_next;
                    flag_d     = flag_next;
                    win_cnt_d  = win_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One-deep result register with drop-on-full and sticky overrun
    always_comb begin
        code_d       = code_q;
        sat_d        = sat_q;
        code_valid_d = code_valid_q;
        overrun_d    = overrun_q;
        if (close) begin
            if (!code_valid_q || code_ready) begin
                code_d       = close_cnt;
                sat_d        = close_sat;
                code_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (code_valid_q && code_ready) begin
            code_valid_d = 1'b0;
        end
    end

    // State, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
            win_cnt_q    <= '0;
            flag_q       <= 1'b0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            sat_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            win_cnt_q    <= win_cnt_d;
            flag_q       <= flag_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            sat_q        <= sat_d;
            overrun_q    <= overrun_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign sat        = sat_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule
